jtag_ocimem_monitor: RTL

Debug-memory access engine in the CPU system-clock domain, directly downstream of the JTAG debug module's sysclk stage. Consumes jdo and the ocimem take_action strobes and runs single-word reads/writes on an Avalon-MM master port. Returns MonDReg, monitor_ready and monitor_error upstream to the JTAG tck stage for scan-out.

---
 rtl/jtag_ocimem_monitor_pkg.sv | 24 ++
 rtl/jtag_ocimem_monitor_if.sv | 32 +++
 rtl/jtag_ocimem_monitor_watchdog.sv | 39 +++
 rtl/jtag_ocimem_monitor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/jtag_ocimem_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ocimem_pkg
// Shared definitions for the JTAG on-chip-memory monitor engine:
//   - state_t      : engine states
//   - jdo field positions (address LSB, read-flag bit, write-data MSB/LSB)
//   - TIMEOUT_FILL : value loaded into MonDReg when a bus access is aborted
// ---------------------------------------------------------------------------
package ocimem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_REQ  = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_WR_REQ  = 2'd3
   } state_t;

   localparam int ADDR_LSB   = 17;
   localparam int RDFLAG_BIT = 34;
   localparam int WDATA_MSB  = 34;
   localparam int WDATA_LSB  = 3;

   localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/jtag_ocimem_monitor_if.sv
// ---------------------------------------------------------------------------
// jtag_ocimem_monitor_if
// Avalon-MM single-word master bus between the monitor engine and the
// memory slave.
//   avm_address       byte address (ADDR_W+2 bits)
//   avm_read/write    request strobes, held until waitrequest drops
//   avm_writedata     write data
//   avm_readdata      read data, qualified by avm_readdatavalid
//   avm_waitrequest   slave stall
// Modports: master (engine side), slave (memory side).
// ---------------------------------------------------------------------------
interface jtag_ocimem_monitor_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W+1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;
   logic              avm_readdatavalid;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest, avm_readdatavalid
   );
endinterface

// File: rtl/jtag_ocimem_monitor_watchdog.sv
// ---------------------------------------------------------------------------
// ocimem_watchdog
// Counts cycles spent away from IDLE and flags the cycle on which a bus
// access has been outstanding for TIMEOUT_CYCLES cycles.
//   clk, reset  system clock, synchronous active-high reset
//   busy        engine is in a bus state (counter runs; cleared otherwise)
//   expired     high during the TIMEOUT_CYCLES-th consecutive busy cycle
// ---------------------------------------------------------------------------
module ocimem_watchdog #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic busy,
   output logic expired
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter reads 0 in the first busy cycle because it is held at zero
   // while idle, so the terminal compare is against TIMEOUT_CYCLES-1.
   always_comb begin
      cnt_d = '0;
      if (busy) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign expired = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/jtag_ocimem_monitor.sv
// ---------------------------------------------------------------------------
// jtag_ocimem_monitor
// Debug-memory access engine in the system-clock domain. Takes the jdo
// register and ocimem take_action strobes from the JTAG sysclk stage and
// performs single-word reads/writes on an Avalon-MM master port.
//   clk, reset               system clock, synchronous active-high reset
//   jdo                      JTAG data-out register contents
//   take_action_ocimem_a     load address (and read if jdo read flag set)
//   take_no_action_ocimem_a  read at current address
//   take_action_ocimem_b     write jdo data at current address
//   avm                      Avalon-MM master (jtag_ocimem_monitor_if)
//   MonDReg                  last read data / last written data
//   monitor_ready            engine idle, MonDReg valid
//   monitor_error            sticky: command overrun or bus timeout
// Build option: define OCIMEM_TIMEOUT_EN to abort accesses that stall for
// TIMEOUT_CYCLES cycles (MonDReg <= 32'hDEAD_BEEF, monitor_error <= 1).
// ---------------------------------------------------------------------------
module jtag_ocimem_monitor
   import ocimem_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [37:0]           jdo,
   input  logic                  take_action_ocimem_a,
   input  logic                  take_no_action_ocimem_a,
   input  logic                  take_action_ocimem_b,
   jtag_ocimem_monitor_if.master avm,
   output logic [31:0]           MonDReg,
   output logic                  monitor_ready,
   output logic                  monitor_error
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] areg_q, areg_d;
   logic [31:0]       dreg_q, dreg_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              any_strobe;
   logic              timeout;
   logic [ADDR_W-1:0] areg_inc;
   logic              unused_jdo;

   // Bits of jdo outside the address and data fields carry no meaning here.
   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

`ifdef OCIMEM_TIMEOUT_EN
   ocimem_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .busy    (state_q != ST_IDLE),
      .expired (timeout)
   );
`else
   // No watchdog: accesses wait indefinitely. The expression is constant
   // false; it only keeps TIMEOUT_CYCLES referenced in this build.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign areg_inc   = areg_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      areg_d  = areg_q;
      dreg_d  = dreg_q;
      wdata_d = wdata_q;
      error_d = error_q;

      case (state_q)
         ST_IDLE: begin
            // Priority b > a > no_action; losers are dropped without error.
            if (take_action_ocimem_b) begin
               wdata_d = jdo[WDATA_MSB:WDATA_LSB];
               dreg_d  = jdo[WDATA_MSB:WDATA_LSB];
               error_d = 1'b0;
               state_d = ST_WR_REQ;
            end else if (take_action_ocimem_a) begin
               areg_d  = jdo[ADDR_LSB +: ADDR_W];
               error_d = 1'b0;
               if (jdo[RDFLAG_BIT]) begin
                  state_d = ST_RD_REQ;
               end
            end else if (take_no_action_ocimem_a) begin
               error_d = 1'b0;
               state_d = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            if (!avm.avm_waitrequest) begin
               // Zero-latency slaves may return data in the accept cycle.
               if (avm.avm_readdatavalid) begin
                  dreg_d  = avm.avm_readdata;
                  areg_d  = areg_inc;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            if (avm.avm_readdatavalid) begin
               dreg_d  = avm.avm_readdata;
               areg_d  = areg_inc;
               state_d = ST_IDLE;
            end
         end
         ST_WR_REQ: begin
            if (!avm.avm_waitrequest) begin
               areg_d  = areg_inc;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Commands arriving while busy are overruns.
      if ((state_q != ST_IDLE) && any_strobe) begin
         error_d = 1'b1;
      end

      // Abort only if the access did not complete in the same cycle.
      if (timeout && (state_d != ST_IDLE)) begin
         state_d = ST_IDLE;
         dreg_d  = TIMEOUT_FILL;
         error_d = 1'b1;
      end

      ready_d = (state_d == ST_IDLE);
      rd_d    = (state_d == ST_RD_REQ);
      wr_d    = (state_d == ST_WR_REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         areg_q  <= '0;
         dreg_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b1;
         error_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         areg_q  <= areg_d;
         dreg_q  <= dreg_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   // Address and write data only change on completion or acceptance, so
   // they stay stable while a request is stalled.
   assign avm.avm_address   = {areg_q, 2'b00};
   assign avm.avm_read      = rd_q;
   assign avm.avm_write     = wr_q;
   assign avm.avm_writedata = wdata_q;
   assign MonDReg           = dreg_q;
   assign monitor_ready     = ready_q;
   assign monitor_error     = error_q;
endmodule
